// File: rtl/lstm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lstm_ctrl_pkg
// Shared definitions for the LSTM timestep sequencer and its watchdog.
//   state_t       : sequencer state encoding (3 bits, all codes used)
//   CELL_PHASES   : cell pipeline stage count (IDLE->S1->S2->S3 pass = 4 clocks)
//   PHASE_BITS    : width of the cell phase counter
//   WDOG_LIM_DEF  : default watchdog limit in clock cycles
//   is_wait_state : states in which the watchdog is running
// -----------------------------------------------------------------------------
package lstm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MAC    = 3'd1,
    CELL   = 3'd2,
    WRITE  = 3'd3,
    READ   = 3'd4,
    NEXT   = 3'd5,
    FINISH = 3'd6,
    ERR    = 3'd7
  } state_t;

  // Must equal the number of stages the cell walks through per timestep.
  localparam int CELL_PHASES  = 4;
  localparam int PHASE_BITS   = $clog2(CELL_PHASES);
  localparam int WDOG_LIM_DEF = 40;

  function automatic logic is_wait_state(input state_t s);
    return (s == MAC) || (s == WRITE) || (s == READ);
  endfunction

endpackage

// File: rtl/lstm_wdog.sv
// -----------------------------------------------------------------------------
// lstm_wdog
// Cycle-limit watchdog. It counts the cycles of a monitored window and flags,
// as a registered output, the cycle in which the window has lasted i_limit
// cycles. The controls describe the *upcoming* cycle so that the flag lines up
// with the cycle it refers to:
//   i_enable : the next cycle belongs to a monitored window
//   i_clear  : the next cycle is the first cycle of a new window
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : restart the window count
//   i_enable   : next cycle is monitored (otherwise count returns to 0)
//   i_limit    : window length in cycles
//   o_expired  : high in the cycle where the window length reaches i_limit
// -----------------------------------------------------------------------------
module lstm_wdog #(
  parameter int WDOG_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [WDOG_BITS-1:0] i_limit,
  output logic                 o_expired
);

  logic [WDOG_BITS-1:0] r_count;
  logic [WDOG_BITS-1:0] w_count_next;
  logic                 r_expired;

  // r_count holds the number of window cycles elapsed including the current
  // one; it saturates rather than wrapping so a long wait stays expired.
  always_comb begin
    w_count_next = '0;
    if (i_enable) begin
      if (i_clear) begin
        w_count_next = WDOG_BITS'(1);
      end else if (r_count != '1) begin
        w_count_next = r_count + WDOG_BITS'(1);
      end else begin
        w_count_next = r_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_expired <= i_enable && (w_count_next >= i_limit);
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lstm_seq_ctrl
// Timestep sequencer for one LSTM cell and its two gate weight engines.
// Per timestep: pulse mac_start, wait for both engines, enable the cell clock
// for one full 4-phase pass, wait for the output-buffer write, drive the
// hidden-state read-back, then advance to the next timestep or finish.
// Ports:
//   sys_clk, reset_n : clock, asynchronous active-low reset
//   start, abort     : one-cycle run request, synchronous abort (wins always)
//   num_steps        : timesteps per run, sampled on an accepted start
//   busy             : run in progress (decoded from state)
//   done             : one-cycle run-complete pulse
//   error            : watchdog error, held until abort or a new start
//   step_idx         : current 0-based timestep
//   mac_start        : start pulse to both weight engines
//   w1_done, w2_done : engine completion (pulse or level)
//   cell_clk_en      : cell clock gate enable
//   cell_w_ready     : weights-ready to the cell (done_w1/done_w2)
//   wr_done          : cell output-buffer write complete
//   read_output      : cell hidden-state read-back request
//   re_done          : cell read-back complete
// -----------------------------------------------------------------------------
module lstm_seq_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int                   STEP_BITS = 8,
  parameter int                   WDOG_BITS = 6,
  parameter logic [WDOG_BITS-1:0] WDOG_LIM  = WDOG_BITS'(WDOG_LIM_DEF)
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [STEP_BITS-1:0] num_steps,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [STEP_BITS-1:0] step_idx,
  output logic                 mac_start,
  input  logic                 w1_done,
  input  logic                 w2_done,
  output logic                 cell_clk_en,
  output logic                 cell_w_ready,
  input  logic                 wr_done,
  output logic                 read_output,
  input  logic                 re_done
);

  state_t                r_state;
  state_t                w_state_next;
  logic [STEP_BITS-1:0]  r_num_steps, w_num_steps_next;
  logic [STEP_BITS-1:0]  r_step_idx, w_step_idx_next;
  logic [PHASE_BITS-1:0] r_phase, w_phase_next;
  logic                  r_f1, r_f2, w_f1_next, w_f2_next;
  logic                  w_f1_seen, w_f2_seen;
  logic                  w_zero_run;
  logic                  r_done, r_error, r_mac_start, r_cell_en, r_read_output;
  logic                  w_done_next, w_error_next, w_mac_start_next;
  logic                  w_cell_en_next, w_read_next;
  logic                  w_wdog_clear, w_wdog_enable, w_wdog_expired;

  // A completion that arrives in the same cycle as the flag check counts,
  // so both engines finishing in the MAC entry cycle exits MAC immediately.
  assign w_f1_seen = r_f1 | w1_done;
  assign w_f2_seen = r_f2 | w2_done;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_num_steps_next = r_num_steps;
    w_step_idx_next  = r_step_idx;
    w_zero_run       = 1'b0;

    case (r_state)
      IDLE, ERR: begin
        if (start) begin
          if (num_steps != '0) begin
            w_num_steps_next = num_steps;
            w_step_idx_next  = '0;
            w_state_next     = MAC;
          end else begin
            // Empty run: acknowledge with done and stay put.
            w_zero_run   = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      MAC: begin
        // A real completion wins over a watchdog expiring in the same cycle.
        if (w_f1_seen && w_f2_seen) w_state_next = CELL;
        else if (w_wdog_expired)    w_state_next = ERR;
      end
      CELL: begin
        if (r_phase == PHASE_BITS'(CELL_PHASES - 1)) w_state_next = WRITE;
      end
      WRITE: begin
        if (wr_done)             w_state_next = READ;
        else if (w_wdog_expired) w_state_next = ERR;
      end
      READ: begin
        if (re_done)             w_state_next = NEXT;
        else if (w_wdog_expired) w_state_next = ERR;
      end
      NEXT: begin
        if (r_step_idx == r_num_steps - STEP_BITS'(1)) begin
          w_state_next = FINISH;
        end else begin
          w_step_idx_next = r_step_idx + STEP_BITS'(1);
          w_state_next    = MAC;
        end
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // Abort overrides everything; step_idx and the latched count hold.
    if (abort) begin
      w_state_next     = IDLE;
      w_num_steps_next = r_num_steps;
      w_step_idx_next  = r_step_idx;
      w_zero_run       = 1'b0;
    end
  end

  // Registered strobes are decoded from the next state so each one is valid
  // in exactly the cycles spent in its state.
  assign w_mac_start_next = (w_state_next == MAC) && (r_state != MAC);
  assign w_cell_en_next   = (w_state_next == CELL);
  assign w_read_next      = (w_state_next == READ);
  assign w_done_next      = (w_state_next == FINISH) || w_zero_run;
  assign w_error_next     = (w_state_next == ERR);

  // Engine flags only live while MAC continues; leaving MAC drops them.
  assign w_f1_next = (r_state == MAC) && (w_state_next == MAC) && w_f1_seen;
  assign w_f2_next = (r_state == MAC) && (w_state_next == MAC) && w_f2_seen;

  assign w_phase_next = ((r_state == CELL) && (w_state_next == CELL)) ?
                        (r_phase + PHASE_BITS'(1)) : '0;

  assign w_wdog_clear  = (w_state_next != r_state);
  assign w_wdog_enable = is_wait_state(w_state_next);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num_steps   <= '0;
      r_step_idx    <= '0;
      r_phase       <= '0;
      r_f1          <= 1'b0;
      r_f2          <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_mac_start   <= 1'b0;
      r_cell_en     <= 1'b0;
      r_read_output <= 1'b0;
    end else begin
      r_num_steps   <= w_num_steps_next;
      r_step_idx    <= w_step_idx_next;
      r_phase       <= w_phase_next;
      r_f1          <= w_f1_next;
      r_f2          <= w_f2_next;
      r_done        <= w_done_next;
      r_error       <= w_error_next;
      r_mac_start   <= w_mac_start_next;
      r_cell_en     <= w_cell_en_next;
      r_read_output <= w_read_next;
    end
  end

  lstm_wdog #(
    .WDOG_BITS (WDOG_BITS)
  ) u_wdog (
    .clk       (sys_clk),
    .rst_n     (reset_n),
    .i_clear   (w_wdog_clear),
    .i_enable  (w_wdog_enable),
    .i_limit   (WDOG_LIM),
    .o_expired (w_wdog_expired)
  );

  assign busy         = (r_state == MAC) || (r_state == CELL) || (r_state == WRITE) ||
                        (r_state == READ) || (r_state == NEXT);
  assign done         = r_done;
  assign error        = r_error;
  assign step_idx     = r_step_idx;
  assign mac_start    = r_mac_start;
  assign cell_clk_en  = r_cell_en;
  assign cell_w_ready = r_cell_en;
  assign read_output  = r_read_output;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lstm_seq_ctrl
// Directed bench for lstm_seq_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are checked at the same point, i.e. away from the edge.
// -----------------------------------------------------------------------------
module tb_lstm_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_steps = 8'd0;
  logic       w1_done = 1'b0;
  logic       w2_done = 1'b0;
  logic       wr_done = 1'b0;
  logic       re_done = 1'b0;
  logic       busy, done, error, mac_start, cell_clk_en, cell_w_ready, read_output;
  logic [7:0] step_idx;

  int n_checks = 0;
  int n_errors = 0;
  int mac_pulses = 0;
  int cell_cycles = 0;
  int done_pulses = 0;

  lstm_seq_ctrl dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .num_steps    (num_steps),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .step_idx     (step_idx),
    .mac_start    (mac_start),
    .w1_done      (w1_done),
    .w2_done      (w2_done),
    .cell_clk_en  (cell_clk_en),
    .cell_w_ready (cell_w_ready),
    .wr_done      (wr_done),
    .read_output  (read_output),
    .re_done      (re_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Running totals of strobe activity, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (mac_start === 1'b1)   mac_pulses  <= mac_pulses + 1;
    if (cell_clk_en === 1'b1) cell_cycles <= cell_cycles + 1;
    if (done === 1'b1)        done_pulses <= done_pulses + 1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    chk1("pre_start_busy", busy, 1'b0);
    start     = 1'b1;
    num_steps = n[7:0];
    tick();
    start     = 1'b0;
  endtask

  // Called in the MAC entry cycle. a/b: MAC cycle of w1/w2_done, d: WRITE
  // cycle of wr_done, e: READ cycle of re_done.
  task automatic run_step(input int idx, input int a, input int b,
                          input int d, input int e, input bit last);
    int mx;
    mx = (a > b) ? a : b;
    for (int c = 0; c <= mx; c++) begin
      w1_done = (c == a);
      w2_done = (c == b);
      chk1("mac_start", mac_start, c == 0);
      chk1("mac_cell_en", cell_clk_en, 1'b0);
      chk1("mac_busy", busy, 1'b1);
      chkv("mac_idx", 32'(step_idx), idx);
      tick();
    end
    w1_done = 1'b0;
    w2_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk1("cell_en", cell_clk_en, 1'b1);
      chk1("cell_w_ready", cell_w_ready, 1'b1);
      chk1("cell_mac_start", mac_start, 1'b0);
      tick();
    end
    for (int c = 0; c <= d; c++) begin
      wr_done = (c == d);
      chk1("write_cell_en", cell_clk_en, 1'b0);
      chk1("write_read_out", read_output, 1'b0);
      tick();
    end
    wr_done = 1'b0;
    for (int c = 0; c <= e; c++) begin
      re_done = (c == e);
      chk1("read_out", read_output, 1'b1);
      chk1("read_busy", busy, 1'b1);
      tick();
    end
    re_done = 1'b0;
    chk1("next_read_out", read_output, 1'b0);
    chk1("next_busy", busy, 1'b1);
    chk1("next_done", done, 1'b0);
    tick();
    if (last) begin
      chk1("finish_done", done, 1'b1);
      chk1("finish_busy", busy, 1'b0);
      chkv("finish_idx", 32'(step_idx), idx);
      tick();
      chk1("idle_done", done, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end else begin
      chk1("next_mac_start", mac_start, 1'b1);
      chkv("next_idx", 32'(step_idx), idx + 1);
    end
  endtask

  initial begin
    int m0, c0, d0;

    // Reset state
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_mac_start", mac_start, 1'b0);
    chk1("rst_cell_en", cell_clk_en, 1'b0);
    chk1("rst_w_ready", cell_w_ready, 1'b0);
    chk1("rst_read_out", read_output, 1'b0);
    chkv("rst_idx", 32'(step_idx), 0);
    reset_n = 1'b1;
    tick();

    // Three-step run with staggered engine and cell handshakes
    do_start(3);
    m0 = mac_pulses;
    c0 = cell_cycles;
    d0 = done_pulses;
    run_step(0, 2, 5, 6, 5, 1'b0);
    run_step(1, 2, 5, 6, 5, 1'b0);
    run_step(2, 2, 5, 6, 5, 1'b1);
    tick();
    chkv("run3_mac_pulses", mac_pulses - m0, 3);
    chkv("run3_cell_cycles", cell_cycles - c0, 12);
    chkv("run3_done_pulses", done_pulses - d0, 1);
    chk1("run3_busy_after", busy, 1'b0);

    // Both engines done in MAC entry cycle; then w2 before w1
    do_start(1);
    run_step(0, 0, 0, 0, 0, 1'b1);
    do_start(1);
    run_step(0, 3, 1, 1, 1, 1'b1);

    // num_steps = 0: done pulse only
    m0 = mac_pulses;
    do_start(0);
    chk1("zero_done", done, 1'b1);
    chk1("zero_busy", busy, 1'b0);
    chk1("zero_mac_start", mac_start, 1'b0);
    tick();
    chk1("zero_done_clear", done, 1'b0);
    chk1("zero_busy2", busy, 1'b0);
    tick();
    chkv("zero_mac_pulses", mac_pulses - m0, 0);

    // Watchdog: wr_done withheld
    do_start(1);
    w1_done = 1'b1;
    w2_done = 1'b1;
    tick();
    w1_done = 1'b0;
    w2_done = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    for (int c = 0; c < 40; c++) begin
      chk1("wd_error_low", error, 1'b0);
      chk1("wd_write_busy", busy, 1'b1);
      chk1("wd_read_out", read_output, 1'b0);
      tick();
    end
    chk1("wd_error_set", error, 1'b1);
    chk1("wd_err_busy", busy, 1'b0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk1("wd_late_wr_read_out", read_output, 1'b0);
    chk1("wd_error_held", error, 1'b1);
    tick();
    tick();
    chk1("wd_error_held2", error, 1'b1);
    chk1("wd_read_out2", read_output, 1'b0);
    start     = 1'b1;
    num_steps = 8'd1;
    tick();
    start     = 1'b0;
    chk1("wd_restart_error", error, 1'b0);
    run_step(0, 1, 0, 2, 3, 1'b1);

    // Abort in CELL phase 2, with a simultaneous start
    do_start(2);
    w1_done = 1'b1;
    w2_done = 1'b1;
    tick();
    w1_done = 1'b0;
    w2_done = 1'b0;
    tick();
    tick();
    chk1("abort_pre_cell_en", cell_clk_en, 1'b1);
    abort     = 1'b1;
    start     = 1'b1;
    num_steps = 8'd5;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk1("abort_cell_en", cell_clk_en, 1'b0);
    chk1("abort_w_ready", cell_w_ready, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_mac_start", mac_start, 1'b0);
    chkv("abort_idx", 32'(step_idx), 0);
    m0 = mac_pulses;
    d0 = done_pulses;
    for (int c = 0; c < 3; c++) tick();
    chkv("abort_no_mac", mac_pulses - m0, 0);
    chkv("abort_no_done", done_pulses - d0, 0);
    chk1("abort_busy_late", busy, 1'b0);

    // Asynchronous reset in READ
    do_start(1);
    w1_done = 1'b1;
    w2_done = 1'b1;
    tick();
    w1_done = 1'b0;
    w2_done = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk1("rr_read_out", read_output, 1'b1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rr_read_out_low", read_output, 1'b0);
    chk1("rr_busy", busy, 1'b0);
    chk1("rr_cell_en", cell_clk_en, 1'b0);
    chk1("rr_done", done, 1'b0);
    chk1("rr_error", error, 1'b0);
    chk1("rr_mac_start", mac_start, 1'b0);
    chkv("rr_idx", 32'(step_idx), 0);
    tick();
    reset_n = 1'b1;
    tick();
    do_start(1);
    run_step(0, 1, 1, 2, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
